bulls_cows_engine: RTL and testbench

BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

---
 rtl/bulls_cows_pkg.sv | 21 ++
 rtl/bc_code_check.sv | 26 ++
 rtl/bulls_cows_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_bulls_cows_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bulls_cows_pkg.sv
// Shared types and constants for the Bulls & Cows engine.
// Holds the FSM state encoding, the default parameter values and the
// highest legal decimal digit.
package bulls_cows_pkg;

  localparam int unsigned NUM_DIGITS_DEF   = 4;
  localparam int unsigned DIGIT_W_DEF      = 4;
  localparam int unsigned NUM_PLAYERS_DEF  = 2;
  localparam int unsigned MAX_ATTEMPTS_DEF = 15;
  localparam int unsigned DIGIT_MAX        = 9;

  typedef enum logic [2:0] {
    SECRET = 3'd0,
    GUESS  = 3'd1,
    SCORE  = 3'd2,
    RESULT = 3'd3,
    WIN    = 3'd4,
    FIM    = 3'd5
  } state_t;

endpackage

// File: rtl/bc_code_check.sv
// Combinational legality check of a code: every digit must be a decimal
// digit (0..DIGIT_MAX) and no two digits may be equal.
// Ports:
//   code_i       packed code, digit 0 in the LSBs
//   code_legal_o high when the code is legal
module bc_code_check
  import bulls_cows_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned DIGIT_W    = DIGIT_W_DEF
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code_i,
  output logic                          code_legal_o
);

  always_comb begin
    code_legal_o = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (32'(code_i[i*DIGIT_W +: DIGIT_W]) > DIGIT_MAX) code_legal_o = 1'b0;
      for (int unsigned j = i + 1; j < NUM_DIGITS; j++) begin
        if (code_i[i*DIGIT_W +: DIGIT_W] == code_i[j*DIGIT_W +: DIGIT_W]) code_legal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Multi-player Bulls & Cows game engine.
// Each player enters a secret, then players take turns guessing the secret
// of the next player. A guess is scored one digit per cycle.
// Ports:
//   clock_i, reset_i   rising-edge clock, synchronous active-high reset
//   guess_i            code entry, digit 0 in the LSBs
//   confirm_i          level input, its rising edge is the confirm event
//   state_o, player_o  current FSM state and active player
//   bulls_o, cows_o    last score, result_valid_o pulses when they update
//   attempts_o         guesses used by the active player
//   winner_o           winning player, meaningful in WIN
//   reject_o           pulses when a confirmed code is illegal
module bulls_cows_engine
  import bulls_cows_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int unsigned DIGIT_W      = DIGIT_W_DEF,
  parameter int unsigned NUM_PLAYERS  = NUM_PLAYERS_DEF,
  parameter int unsigned MAX_ATTEMPTS = MAX_ATTEMPTS_DEF
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       guess_i,
  input  logic                                confirm_i,
  output state_t                              state_o,
  output logic [$clog2(NUM_PLAYERS)-1:0]      player_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     bulls_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     cows_o,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_o,
  output logic [$clog2(NUM_PLAYERS)-1:0]      winner_o,
  output logic                                result_valid_o,
  output logic                                reject_o
);

  localparam int unsigned PW = $clog2(NUM_PLAYERS);
  localparam int unsigned SW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned CW = NUM_DIGITS * DIGIT_W;

  state_t           state_q, state_d;
  logic [PW-1:0]    player_q, player_d, winner_q, winner_d;
  logic [SW-1:0]    bulls_q, bulls_d, cows_q, cows_d;
  logic [SW-1:0]    bacc_q, bacc_d, cacc_q, cacc_d;
  logic [AW-1:0]    att_q [NUM_PLAYERS];
  logic [AW-1:0]    att_d [NUM_PLAYERS];
  logic [AW-1:0]    att_o_q, att_o_d;
  logic [CW-1:0]    secret_q [NUM_PLAYERS];
  logic [CW-1:0]    secret_d [NUM_PLAYERS];
  logic [CW-1:0]    guess_q, guess_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             result_valid_q, result_valid_d, reject_q, reject_d;
  logic             confirm_q, armed_q;

  logic             event_c, code_legal_c;
  logic [PW-1:0]    target_c, next_player_c;
  logic [DIGIT_W-1:0] gdig_c;
  logic [CW-1:0]    tsec_c;
  logic             bull_hit_c, cow_hit_c, any_left_c;
  logic [SW-1:0]    bsum_c, csum_c;

  // armed_q blocks an event until confirm has been seen low since reset,
  // so a level held through reset release is not taken as a press.
  assign event_c = confirm_i & ~confirm_q & armed_q;

  bc_code_check #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_code_check (
    .code_i       (guess_i),
    .code_legal_o (code_legal_c)
  );

  // Single-digit score step: current guess digit against all target digits.
  always_comb begin
    target_c = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);
    gdig_c   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) gdig_c = guess_q[i*DIGIT_W +: DIGIT_W];
    end
    tsec_c     = secret_q[target_c];
    bull_hit_c = 1'b0;
    cow_hit_c  = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (tsec_c[j*DIGIT_W +: DIGIT_W] == gdig_c) begin
        if (idx_q == IW'(j)) bull_hit_c = 1'b1;
        else                 cow_hit_c  = 1'b1;
      end
    end
    bsum_c = bacc_q + SW'(bull_hit_c);
    csum_c = cacc_q + SW'(cow_hit_c);
  end

  // Next player with guesses left, searching forward and wrapping.
  always_comb begin
    next_player_c = player_q;
    any_left_c    = 1'b0;
    for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
      if (!any_left_c && att_q[PW'((32'(player_q) + k) % NUM_PLAYERS)] < AW'(MAX_ATTEMPTS)) begin
        next_player_c = PW'((32'(player_q) + k) % NUM_PLAYERS);
        any_left_c    = 1'b1;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    player_d       = player_q;
    winner_d       = winner_q;
    bulls_d        = bulls_q;
    cows_d         = cows_q;
    bacc_d         = bacc_q;
    cacc_d         = cacc_q;
    att_d          = att_q;
    secret_d       = secret_q;
    guess_d        = guess_q;
    idx_d          = idx_q;
    result_valid_d = 1'b0;
    reject_d       = 1'b0;

    unique case (state_q)
      SECRET: begin
        if (event_c) begin
          if (!code_legal_c) begin
            reject_d = 1'b1;
          end else begin
            secret_d[player_q] = guess_i;
            if (player_q == PW'(NUM_PLAYERS - 1)) begin
              player_d = '0;
              state_d  = GUESS;
            end else begin
              player_d = player_q + PW'(1);
            end
          end
        end
      end
      GUESS: begin
        if (event_c) begin
          if (!code_legal_c) begin
            reject_d = 1'b1;
          end else begin
            guess_d = guess_i;
            if (att_q[player_q] < AW'(MAX_ATTEMPTS)) att_d[player_q] = att_q[player_q] + AW'(1);
            idx_d   = '0;
            bacc_d  = '0;
            cacc_d  = '0;
            state_d = SCORE;
          end
        end
      end
      SCORE: begin
        // Confirm events are dropped here, never queued.
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          bulls_d        = bsum_c;
          cows_d         = csum_c;
          result_valid_d = 1'b1;
          state_d        = RESULT;
        end else begin
          idx_d  = idx_q + IW'(1);
          bacc_d = bsum_c;
          cacc_d = csum_c;
        end
      end
      RESULT: begin
        if (bulls_q == SW'(NUM_DIGITS)) begin
          winner_d = player_q;
          state_d  = WIN;
        end else if (event_c) begin
          if (!any_left_c) begin
            state_d = FIM;
          end else begin
            player_d = next_player_c;
            state_d  = GUESS;
          end
        end
      end
      WIN, FIM: begin
        if (event_c) begin
          state_d  = SECRET;
          player_d = '0;
          bulls_d  = '0;
          cows_d   = '0;
          for (int unsigned p = 0; p < NUM_PLAYERS; p++) att_d[p] = '0;
        end
      end
      default: state_d = SECRET;
    endcase

    att_o_d = att_d[player_d];
  end

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= SECRET;
      player_q       <= '0;
      winner_q       <= '0;
      bulls_q        <= '0;
      cows_q         <= '0;
      bacc_q         <= '0;
      cacc_q         <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        att_q[p]    <= '0;
        secret_q[p] <= '0;
      end
      att_o_q        <= '0;
      guess_q        <= '0;
      idx_q          <= '0;
      result_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      confirm_q      <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      player_q       <= player_d;
      winner_q       <= winner_d;
      bulls_q        <= bulls_d;
      cows_q         <= cows_d;
      bacc_q         <= bacc_d;
      cacc_q         <= cacc_d;
      att_q          <= att_d;
      secret_q       <= secret_d;
      att_o_q        <= att_o_d;
      guess_q        <= guess_d;
      idx_q          <= idx_d;
      result_valid_q <= result_valid_d;
      reject_q       <= reject_d;
      confirm_q      <= confirm_i;
      armed_q        <= armed_q | ~confirm_i;
    end
  end

  assign state_o        = state_q;
  assign player_o       = player_q;
  assign winner_o       = winner_q;
  assign bulls_o        = bulls_q;
  assign cows_o         = cows_q;
  assign attempts_o     = att_o_q;
  assign result_valid_o = result_valid_q;
  assign reject_o       = reject_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Scoreboard bench for bulls_cows_engine: expected reject / score pulses are
// queued as stimulus is issued and checked by an independent monitor.
module tb_bulls_cows_engine;
  import bulls_cows_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned MA = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          confirm;
  logic [15:0]   guess;
  state_t        state;
  logic [0:0]    player, winner;
  logic [2:0]    bulls, cows;
  logic [1:0]    attempts;
  logic          rv, rej;

  always #5 clk = ~clk;

  bulls_cows_engine #(
    .NUM_DIGITS   (ND),
    .DIGIT_W      (DW),
    .NUM_PLAYERS  (NP),
    .MAX_ATTEMPTS (MA)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .guess_i        (guess),
    .confirm_i      (confirm),
    .state_o        (state),
    .player_o       (player),
    .bulls_o        (bulls),
    .cows_o         (cows),
    .attempts_o     (attempts),
    .winner_o       (winner),
    .result_valid_o (rv),
    .reject_o       (rej)
  );

  typedef struct {
    bit is_rej;
    int b;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every reject / result_valid pulse must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rv || rej) begin
        if (exp_q.size() == 0) begin
          chk(rv ? "unexpected_result_valid" : "unexpected_reject", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_is_reject", int'(rej), int'(e.is_rej));
          if (!e.is_rej) begin
            chk("bulls", int'(bulls), e.b);
            chk("cows", int'(cows), e.c);
          end
        end
      end
    end
  end

  task automatic push_res(input int b, input int c);
    exp_t e;
    e.is_rej = 1'b0; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_rej();
    exp_t e;
    e.is_rej = 1'b1; e.b = 0; e.c = 0;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [15:0] code);
    @(negedge clk);
    guess   = code;
    confirm = 1'b1;
    @(negedge clk);
    confirm = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string name, input state_t s, input int budget);
    int n = 0;
    while (state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(state), int'(s));
  endtask

  // Issue a legal guess, count SCORE cycles, optionally poke confirm inside SCORE.
  task automatic guess_and_score(input string name, input logic [15:0] code,
                                 input int b, input int c, input bit poke);
    int n = 0;
    push_res(b, c);
    press(code);
    while (state == SCORE && n < 20) begin
      n++;
      if (poke && n == 1) confirm = 1'b1;
      if (poke && n == 2) confirm = 1'b0;
      @(negedge clk);
    end
    chk({name, "_score_cycles"}, n, ND);
    chk({name, "_result_state"}, int'(state), int'(RESULT));
  endtask

  initial begin
    rst     = 1'b1;
    confirm = 1'b1;
    guess   = 16'h1234;
    idle(3);
    rst = 1'b0;
    idle(3);
    chk("reset_state", int'(state), int'(SECRET));
    chk("reset_player", int'(player), 0);
    chk("reset_winner", int'(winner), 0);
    chk("reset_bulls", int'(bulls), 0);
    chk("reset_cows", int'(cows), 0);
    chk("reset_attempts", int'(attempts), 0);
    confirm = 1'b0;
    idle(1);

    // Game 1: held confirm yields one event.
    @(negedge clk);
    guess   = 16'h1234;
    confirm = 1'b1;
    idle(5);
    confirm = 1'b0;
    idle(1);
    chk("hold_one_event_player", int'(player), 1);
    chk("hold_one_event_state", int'(state), int'(SECRET));
    press(16'h5678);
    chk("secrets_done_state", int'(state), int'(GUESS));
    chk("secrets_done_player", int'(player), 0);

    push_rej();
    press(16'h1123);
    push_rej();
    press(16'h12A4);
    idle(1);
    chk("reject_state_kept", int'(state), int'(GUESS));
    chk("reject_attempts_kept", int'(attempts), 0);

    guess_and_score("p0_5687", 16'h5687, 2, 2, 1'b0);
    chk("p0_attempts_1", int'(attempts), 1);
    press(16'h0000);
    chk("turn_to_p1_state", int'(state), int'(GUESS));
    chk("turn_to_p1_player", int'(player), 1);
    chk("p1_attempts_0", int'(attempts), 0);

    guess_and_score("p1_win", 16'h1234, 4, 0, 1'b0);
    wait_state("win_state", WIN, 5);
    chk("winner_p1", int'(winner), 1);
    press(16'h0000);
    chk("new_game_state", int'(state), int'(SECRET));
    chk("new_game_player", int'(player), 0);
    chk("new_game_attempts", int'(attempts), 0);
    chk("new_game_bulls", int'(bulls), 0);

    // Game 2: exhaust attempts without a win.
    press(16'h1234);
    press(16'h5678);
    guess_and_score("g2_p0_a", 16'h9012, 0, 0, 1'b0);
    press(16'h0000);
    guess_and_score("g2_p1_a", 16'h4321, 0, 4, 1'b1);
    idle(4);
    chk("score_confirm_not_queued", int'(state), int'(RESULT));
    press(16'h0000);
    chk("g2_back_to_p0", int'(player), 0);
    chk("g2_p0_attempts", int'(attempts), 1);
    guess_and_score("g2_p0_b", 16'h5670, 3, 0, 1'b0);
    chk("g2_p0_attempts_max", int'(attempts), 2);
    press(16'h0000);
    chk("g2_p1_player", int'(player), 1);
    chk("g2_p1_attempts", int'(attempts), 1);
    guess_and_score("g2_p1_b", 16'h2143, 0, 4, 1'b0);
    press(16'h0000);
    chk("fim_state", int'(state), int'(FIM));
    press(16'h0000);
    chk("fim_restart_state", int'(state), int'(SECRET));

    // Game 3: reset mid-SCORE aborts without a result pulse.
    press(16'h1234);
    press(16'h5678);
    press(16'h9012);
    chk("g3_in_score", int'(state), int'(SCORE));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    chk("abort_state", int'(state), int'(SECRET));
    chk("abort_player", int'(player), 0);
    chk("abort_attempts", int'(attempts), 0);
    chk("abort_bulls", int'(bulls), 0);

    chk("expected_pulses_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
